axi_ad9162_txseq: RTL and testbench

AXI_AD9162_TXSEQ -- requirements
Module: axi_ad9162_txseq

---
 rtl/axi_ad9162_txseq.sv | 101 ++++++++++
 tb/tb_axi_ad9162_txseq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/axi_ad9162_txseq.sv
// axi_ad9162_txseq: DAC transmit sequencer (link-up settle, optional external sync, run with underflow/status tracking)
module axi_ad9162_txseq #(
  parameter int START_DELAY   = 16,
  parameter int SYNC_TIMEOUT  = 0,
  parameter int UNF_CNT_WIDTH = 16
) (
  input  logic                     dac_clk,
  input  logic                     dac_rstn,
  input  logic                     dac_start,
  input  logic                     dac_stop,
  input  logic                     dac_sync_en,
  input  logic                     dac_sync_ext,
  input  logic                     tx_ready,
  input  logic                     dac_dunf,
  input  logic                     dac_status_clr,
  output logic                     dac_valid,
  output logic                     dac_data_sel,
  output logic                     dac_running,
  output logic [2:0]               dac_state,
  output logic [UNF_CNT_WIDTH-1:0] dac_unf_count,
  output logic                     dac_link_loss,
  output logic                     dac_sync_timeout
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_LINK = 3'd1;
  localparam logic [2:0] S_SETTLE    = 3'd2;
  localparam logic [2:0] S_WAIT_SYNC = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [15:0] SETTLE_INIT = 16'(START_DELAY - 1);
  localparam logic [31:0] TMO_INIT    = 32'(SYNC_TIMEOUT - 1);
  localparam logic        TMO_EN      = (SYNC_TIMEOUT != 0);
  localparam logic [UNF_CNT_WIDTH-1:0] UNF_ONE = UNF_CNT_WIDTH'(1);

  logic [2:0]               state_q, state_d;
  logic [15:0]              settle_q, settle_d;
  logic [31:0]              tmo_q, tmo_d;
  logic [UNF_CNT_WIDTH-1:0] unf_q, unf_d;
  logic                     link_loss_q, link_loss_d;
  logic                     sync_to_q, sync_to_d;
  logic                     unf_hit;

  // State and status registers; async reset clears everything to IDLE/zero
  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      state_q     <= S_IDLE;
      settle_q    <= '0;
      tmo_q       <= '0;
      unf_q       <= '0;
      link_loss_q <= 1'b0;
      sync_to_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      tmo_q       <= tmo_d;
      unf_q       <= unf_d;
      link_loss_q <= link_loss_d;
      sync_to_q   <= sync_to_d;
    end
  end

  // Next-state: stop overrides everything; sync_ext beats link drop and timeout
  always_comb begin
    state_d = state_q;
    if (dac_stop) state_d = S_IDLE;
    else case (state_q)
      S_IDLE:      state_d = dac_start ? S_WAIT_LINK : S_IDLE;
      S_WAIT_LINK: state_d = tx_ready ? S_SETTLE : S_WAIT_LINK;
      S_SETTLE:    state_d = !tx_ready ? S_WAIT_LINK : (settle_q != 16'd0) ? S_SETTLE :
                             dac_sync_en ? S_WAIT_SYNC : S_RUN;
      S_WAIT_SYNC: state_d = dac_sync_ext ? S_RUN : !tx_ready ? S_WAIT_LINK :
                             (TMO_EN && tmo_q == 32'd0) ? S_IDLE : S_WAIT_SYNC;
      S_RUN:       state_d = tx_ready ? S_RUN : S_WAIT_LINK;
      default:     state_d = S_IDLE;
    endcase
  end

  // Counters and stickies; a set event or a counted underflow wins over a same-cycle clear
  always_comb begin
    unf_hit     = dac_dunf && state_q == S_RUN;
    settle_d    = (state_d == S_SETTLE && state_q != S_SETTLE) ? SETTLE_INIT :
                  (state_q == S_SETTLE && settle_q != 16'd0) ? settle_q - 16'd1 : settle_q;
    tmo_d       = (state_d == S_WAIT_SYNC && state_q != S_WAIT_SYNC) ? TMO_INIT :
                  (state_q == S_WAIT_SYNC && tmo_q != 32'd0) ? tmo_q - 32'd1 : tmo_q;
    unf_d       = dac_status_clr ? (unf_hit ? UNF_ONE : '0) :
                  (unf_hit && !(&unf_q)) ? unf_q + UNF_ONE : unf_q;
    link_loss_d = (state_q == S_RUN && state_d == S_WAIT_LINK) || (link_loss_q && !dac_status_clr);
    sync_to_d   = (state_q == S_WAIT_SYNC && state_d == S_IDLE && !dac_stop) ||
                  (sync_to_q && !dac_status_clr);
  end

  // Outputs decode straight from the registers so reset drops them immediately
  always_comb begin
    dac_valid        = state_q == S_RUN;
    dac_data_sel     = state_q == S_RUN;
    dac_running      = state_q == S_RUN;
    dac_state        = state_q;
    dac_unf_count    = unf_q;
    dac_link_loss    = link_loss_q;
    dac_sync_timeout = sync_to_q;
  end
endmodule

// File: tb/tb_axi_ad9162_txseq.sv
// tb_axi_ad9162_txseq: directed self-checking bench for the DAC transmit sequencer
module tb_axi_ad9162_txseq;
  logic       clk = 1'b0;
  logic       rstn, start, stop, sync_en, sync_ext, tx_ready, dunf, clr;
  logic       valid, data_sel, running, link_loss, sync_to;
  logic [2:0] state;
  logic [3:0] unf;
  int total = 0;
  int bad = 0;

  axi_ad9162_txseq #(.START_DELAY(4), .SYNC_TIMEOUT(8), .UNF_CNT_WIDTH(4)) dut (
    .dac_clk(clk), .dac_rstn(rstn), .dac_start(start), .dac_stop(stop),
    .dac_sync_en(sync_en), .dac_sync_ext(sync_ext), .tx_ready(tx_ready),
    .dac_dunf(dunf), .dac_status_clr(clr), .dac_valid(valid),
    .dac_data_sel(data_sel), .dac_running(running), .dac_state(state),
    .dac_unf_count(unf), .dac_link_loss(link_loss), .dac_sync_timeout(sync_to)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rstn = 1'b0; start = 0; stop = 0; sync_en = 0; sync_ext = 0;
    tx_ready = 1; dunf = 0; clr = 0;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_valid", 32'({valid, data_sel, running}), 0);
    chk("rst_unf", 32'(unf), 0);
    chk("rst_sticky", 32'({link_loss, sync_to}), 0);
    tick();
    rstn = 1'b1;
    tick(3);
    chk("idle_hold", 32'(state), 0);
    // Start with sync disabled: WAIT_LINK at 1, SETTLE 2..5, RUN at 6
    start = 1;
    tick();
    start = 0;
    chk("wl_c1", 32'(state), 1);
    tick();
    chk("settle_c2", 32'(state), 2);
    tick(3);
    chk("settle_c5", 32'(state), 2);
    chk("settle_c5_valid", 32'(valid), 0);
    tick();
    chk("run_c6", 32'(state), 4);
    chk("run_outs", 32'({valid, data_sel, running}), 32'b111);
    // Underflow counting and saturation
    dunf = 1;
    tick(3);
    chk("unf_3", 32'(unf), 3);
    tick(17);
    chk("unf_sat", 32'(unf), 15);
    dunf = 0;
    // Link drop in RUN and recovery
    tx_ready = 0;
    tick();
    chk("ll_state", 32'(state), 1);
    chk("ll_valid", 32'(valid), 0);
    chk("ll_sticky", 32'(link_loss), 1);
    tx_ready = 1;
    tick();
    chk("ll_settle", 32'(state), 2);
    tick(4);
    chk("ll_rerun", 32'(state), 4);
    chk("ll_persist", 32'({link_loss, unf}), 32'h1f);
    // Stop in RUN, then underflow in IDLE is ignored
    stop = 1;
    tick();
    stop = 0;
    chk("stop_run", 32'(state), 0);
    dunf = 1;
    tick(3);
    dunf = 0;
    chk("unf_idle", 32'(unf), 15);
    chk("ll_idle_persist", 32'(link_loss), 1);
    // Start and stop together in IDLE
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    chk("start_stop", 32'(state), 0);
    // Stop during SETTLE
    start = 1;
    tick(2);
    start = 0;
    chk("pre_stop_settle", 32'(state), 2);
    stop = 1;
    tick();
    stop = 0;
    chk("stop_settle", 32'(state), 0);
    // Clear coinciding with counted underflow, then clear coinciding with link loss
    start = 1;
    tick();
    start = 0;
    tick(5);
    chk("run2", 32'(state), 4);
    clr = 1; dunf = 1;
    tick();
    dunf = 0;
    chk("clr_unf", 32'(unf), 1);
    chk("clr_ll", 32'(link_loss), 0);
    tx_ready = 0;
    tick();
    clr = 0; tx_ready = 1;
    chk("clr_set_ll", 32'(link_loss), 1);
    chk("clr_set_unf", 32'(unf), 0);
    chk("clr_set_state", 32'(state), 1);
    stop = 1;
    tick();
    stop = 0;
    clr = 1;
    tick();
    clr = 0;
    chk("clr_idle", 32'({state, link_loss}), 0);
    // Sync timeout: WAIT_SYNC at 6..13, IDLE with sticky at 14
    sync_en = 1; start = 1;
    tick();
    start = 0;
    tick(5);
    chk("ws_enter", 32'(state), 3);
    tick(7);
    chk("ws_last", 32'(state), 3);
    chk("ws_no_to", 32'(sync_to), 0);
    tick();
    chk("to_idle", 32'(state), 0);
    chk("to_sticky", 32'(sync_to), 1);
    clr = 1;
    tick();
    clr = 0;
    chk("to_clr", 32'(sync_to), 0);
    // External sync beats link drop in the same cycle
    start = 1;
    tick();
    start = 0;
    tick(6);
    chk("ws2", 32'(state), 3);
    sync_ext = 1; tx_ready = 0;
    tick();
    sync_ext = 0; tx_ready = 1;
    chk("sync_run", 32'(state), 4);
    chk("sync_valid", 32'(valid), 1);
    // Reset mid-RUN clears outputs without a clock edge
    dunf = 1;
    tick(2);
    dunf = 0;
    chk("pre_rst_unf", 32'(unf), 2);
    #2;
    rstn = 0;
    #1;
    chk("arst_outs", 32'({valid, data_sel, running, state}), 0);
    chk("arst_stat", 32'({unf, link_loss, sync_to}), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
